// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with a registered read port, occupancy count,
// threshold flags, back-pressure (Pausa) and a sticky overflow/underflow flag.
// Flags are decoded only from the registered count and the threshold inputs,
// so push/pop never reach a flag combinationally.
module fifo_param #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
  input  logic [ADDR_WIDTH:0]   Umbral_bajo,
  input  logic [ADDR_WIDTH:0]   Umbral_alto,
  input  logic                  err_clear,
  output logic [DATA_WIDTH-1:0] Fifo_Data_out,
  output logic                  Data_valid,
  output logic [ADDR_WIDTH:0]   Umbral,
  output logic                  Fifo_Empty,
  output logic                  Fifo_Full,
  output logic                  Almost_Empty,
  output logic                  Almost_Full,
  output logic                  Pausa,
  output logic                  Error_Fifo
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];

  // Storage is deliberately not reset; after reset the pointers make it unreachable.
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  valid_r;
  logic                  err_r;

  logic                  empty_s;
  logic                  full_s;
  logic                  pop_ok_s;
  logic                  push_ok_s;
  logic                  overflow_s;
  logic                  underflow_s;
  logic [ADDR_WIDTH:0]   count_nxt_s;
  logic                  err_nxt_s;

  // Status decode from the registered count only.
  assign empty_s = (count_r == {(ADDR_WIDTH+1){1'b0}});
  assign full_s  = (count_r == DEPTH_CNT);

  // Acceptance, count update and sticky-error next state.
  always_comb begin
    pop_ok_s    = pop & ~empty_s;
    // A push into a full FIFO is only legal when a pop frees the slot this edge.
    push_ok_s   = push & (~full_s | pop_ok_s);
    overflow_s  = push & full_s & ~pop_ok_s;
    underflow_s = pop & empty_s;

    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + (ADDR_WIDTH+1)'(1);
      2'b01:   count_nxt_s = count_r - (ADDR_WIDTH+1)'(1);
      default: count_nxt_s = count_r;
    endcase

    // A new error on the same edge as err_clear must win over the clear.
    if (overflow_s | underflow_s) begin
      err_nxt_s = 1'b1;
    end else if (err_clear) begin
      err_nxt_s = 1'b0;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // Storage write on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= Fifo_Data_in;
    end
  end

  // Pointer and occupancy registers; pointers wrap modulo DEPTH by width.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r <= {ADDR_WIDTH{1'b0}};
      count_r  <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Registered read port: data holds its last value, valid strobes for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_r <= {DATA_WIDTH{1'b0}};
      valid_r    <= 1'b0;
    end else begin
      if (pop_ok_s) begin
        data_out_r <= mem_r[rd_ptr_r];
      end
      valid_r <= pop_ok_s;
    end
  end

  // Sticky error register.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_nxt_s;
    end
  end

  assign Fifo_Data_out = data_out_r;
  assign Data_valid    = valid_r;
  assign Umbral        = count_r;
  assign Fifo_Empty    = empty_s;
  assign Fifo_Full     = full_s;
  // Umbral_bajo >= DEPTH and Umbral_alto == 0 both saturate naturally to 1.
  assign Almost_Empty  = (count_r <= Umbral_bajo);
  assign Almost_Full   = (count_r >= Umbral_alto);
  assign Pausa         = (count_r >= Umbral_alto) | full_s;
  assign Error_Fifo    = err_r;

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param (DATA_WIDTH=6, DEPTH=8).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [5:0] Fifo_Data_in = 6'd0;
  logic [3:0] Umbral_bajo = 4'd2;
  logic [3:0] Umbral_alto = 4'd6;
  logic       err_clear = 1'b0;
  logic [5:0] Fifo_Data_out;
  logic       Data_valid;
  logic [3:0] Umbral;
  logic       Fifo_Empty;
  logic       Fifo_Full;
  logic       Almost_Empty;
  logic       Almost_Full;
  logic       Pausa;
  logic       Error_Fifo;

  int n_cmp = 0;
  int n_err = 0;

  fifo_param #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .Fifo_Data_in(Fifo_Data_in), .Umbral_bajo(Umbral_bajo), .Umbral_alto(Umbral_alto),
    .err_clear(err_clear), .Fifo_Data_out(Fifo_Data_out), .Data_valid(Data_valid),
    .Umbral(Umbral), .Fifo_Empty(Fifo_Empty), .Fifo_Full(Fifo_Full),
    .Almost_Empty(Almost_Empty), .Almost_Full(Almost_Full), .Pausa(Pausa),
    .Error_Fifo(Error_Fifo)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; push = 1'b0; pop = 1'b0; err_clear = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (Fifo_Empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", Fifo_Empty); end
    n_cmp++; if (Fifo_Full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b exp 0", Fifo_Full); end
    n_cmp++; if (Umbral !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", Umbral); end
    n_cmp++; if (Almost_Empty !== 1'b1) begin n_err++; $display("FAIL reset_ae got %b exp 1", Almost_Empty); end
    n_cmp++; if (Almost_Full !== 1'b0 || Pausa !== 1'b0) begin n_err++; $display("FAIL reset_af_pausa got %b%b exp 00", Almost_Full, Pausa); end
    n_cmp++; if (Error_Fifo !== 1'b0 || Data_valid !== 1'b0) begin n_err++; $display("FAIL reset_err_valid got %b%b exp 00", Error_Fifo, Data_valid); end
    n_cmp++; if (Fifo_Data_out !== 6'd0) begin n_err++; $display("FAIL reset_dout got %h exp 00", Fifo_Data_out); end
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 8; i++) begin
      push = 1'b1; Fifo_Data_in = 6'(i);
      step();
      n_cmp++; if (Umbral !== 4'(i)) begin n_err++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, Umbral, i); end
      n_cmp++; if (Almost_Full !== (i >= 6) || Pausa !== (i >= 6)) begin n_err++; $display("FAIL fill_af_pausa[%0d] got %b%b exp %b", i, Almost_Full, Pausa, (i >= 6)); end
      n_cmp++; if (Fifo_Full !== (i == 8)) begin n_err++; $display("FAIL fill_full[%0d] got %b exp %b", i, Fifo_Full, (i == 8)); end
      n_cmp++; if (Almost_Empty !== (i <= 2)) begin n_err++; $display("FAIL fill_ae[%0d] got %b exp %b", i, Almost_Empty, (i <= 2)); end
      n_cmp++; if (Error_Fifo !== 1'b0) begin n_err++; $display("FAIL fill_err[%0d] got %b exp 0", i, Error_Fifo); end
    end
    push = 1'b0;
  endtask

  task automatic test_overflow;
    push = 1'b1; Fifo_Data_in = 6'h3F;
    step();
    push = 1'b0;
    n_cmp++; if (Umbral !== 4'd8) begin n_err++; $display("FAIL ovf_count got %0d exp 8", Umbral); end
    n_cmp++; if (Error_Fifo !== 1'b1) begin n_err++; $display("FAIL ovf_err got %b exp 1", Error_Fifo); end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    n_cmp++; if (Error_Fifo !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", Error_Fifo); end
  endtask

  task automatic test_full_push_pop;
    push = 1'b1; pop = 1'b1; Fifo_Data_in = 6'h2A;
    step();
    push = 1'b0; pop = 1'b0;
    n_cmp++; if (Fifo_Data_out !== 6'h01 || Data_valid !== 1'b1) begin n_err++; $display("FAIL fpp_read got %h/%b exp 01/1", Fifo_Data_out, Data_valid); end
    n_cmp++; if (Umbral !== 4'd8 || Error_Fifo !== 1'b0) begin n_err++; $display("FAIL fpp_count_err got %0d/%b exp 8/0", Umbral, Error_Fifo); end
    step();
    n_cmp++; if (Data_valid !== 1'b0 || Fifo_Data_out !== 6'h01) begin n_err++; $display("FAIL fpp_hold got %h/%b exp 01/0", Fifo_Data_out, Data_valid); end
  endtask

  task automatic test_drain;
    logic [5:0] exp_q [8];
    exp_q = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h2A};
    for (int k = 0; k < 8; k++) begin
      pop = 1'b1;
      step();
      n_cmp++; if (Fifo_Data_out !== exp_q[k] || Data_valid !== 1'b1) begin n_err++; $display("FAIL drain_data[%0d] got %h/%b exp %h/1", k, Fifo_Data_out, Data_valid, exp_q[k]); end
      n_cmp++; if (Umbral !== 4'(7 - k)) begin n_err++; $display("FAIL drain_count[%0d] got %0d exp %0d", k, Umbral, 7 - k); end
      n_cmp++; if (Almost_Empty !== ((7 - k) <= 2) || Fifo_Empty !== (k == 7)) begin n_err++; $display("FAIL drain_flags[%0d] got ae=%b e=%b", k, Almost_Empty, Fifo_Empty); end
    end
    step();
    pop = 1'b0;
    n_cmp++; if (Error_Fifo !== 1'b1 || Data_valid !== 1'b0) begin n_err++; $display("FAIL udf_err_valid got %b/%b exp 1/0", Error_Fifo, Data_valid); end
    n_cmp++; if (Umbral !== 4'd0 || Fifo_Data_out !== 6'h2A) begin n_err++; $display("FAIL udf_state got %0d/%h exp 0/2a", Umbral, Fifo_Data_out); end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
  endtask

  task automatic test_empty_push_pop;
    push = 1'b1; pop = 1'b1; Fifo_Data_in = 6'h15;
    step();
    push = 1'b0; pop = 1'b0;
    n_cmp++; if (Umbral !== 4'd1 || Data_valid !== 1'b0) begin n_err++; $display("FAIL epp_count_valid got %0d/%b exp 1/0", Umbral, Data_valid); end
    n_cmp++; if (Error_Fifo !== 1'b1) begin n_err++; $display("FAIL epp_err got %b exp 1", Error_Fifo); end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    pop = 1'b1;
    step();
    pop = 1'b0;
    n_cmp++; if (Fifo_Data_out !== 6'h15 || Data_valid !== 1'b1 || Umbral !== 4'd0) begin n_err++; $display("FAIL epp_next got %h/%b/%0d exp 15/1/0", Fifo_Data_out, Data_valid, Umbral); end
    n_cmp++; if (Error_Fifo !== 1'b0) begin n_err++; $display("FAIL epp_clear got %b exp 0", Error_Fifo); end
    // err_clear together with a fresh underflow: the set must win.
    pop = 1'b1; err_clear = 1'b1;
    step();
    pop = 1'b0; err_clear = 1'b0;
    n_cmp++; if (Error_Fifo !== 1'b1) begin n_err++; $display("FAIL set_wins got %b exp 1", Error_Fifo); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; Fifo_Data_in = 6'(8'h31 + i);
      step();
    end
    push = 1'b0;
    n_cmp++; if (Umbral !== 4'd5) begin n_err++; $display("FAIL mid_count got %0d exp 5", Umbral); end
    do_reset();
    n_cmp++; if (Umbral !== 4'd0 || Fifo_Empty !== 1'b1 || Error_Fifo !== 1'b0) begin n_err++; $display("FAIL mid_reset got %0d/%b/%b exp 0/1/0", Umbral, Fifo_Empty, Error_Fifo); end
    pop = 1'b1;
    step();
    pop = 1'b0;
    n_cmp++; if (Fifo_Empty !== 1'b1 || Umbral !== 4'd0 || Data_valid !== 1'b0) begin n_err++; $display("FAIL mid_pop got %b/%0d/%b exp 1/0/0", Fifo_Empty, Umbral, Data_valid); end
    n_cmp++; if (Error_Fifo !== 1'b1 || Fifo_Data_out !== 6'd0) begin n_err++; $display("FAIL mid_err got %b/%h exp 1/00", Error_Fifo, Fifo_Data_out); end
  endtask

  task automatic test_thresholds;
    do_reset();
    Umbral_alto = 4'd0; Umbral_bajo = 4'd8;
    #1;
    n_cmp++; if (Almost_Full !== 1'b1 || Pausa !== 1'b1) begin n_err++; $display("FAIL thr_af0 got %b%b exp 11", Almost_Full, Pausa); end
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; Fifo_Data_in = 6'(i);
      step();
    end
    push = 1'b0;
    n_cmp++; if (Almost_Empty !== 1'b1 || Fifo_Full !== 1'b1) begin n_err++; $display("FAIL thr_ae8 got %b/%b exp 1/1", Almost_Empty, Fifo_Full); end
    Umbral_alto = 4'd6; Umbral_bajo = 4'd2;
    do_reset();
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 10; i++) begin
      push = 1'b1; Fifo_Data_in = 6'(i + 1);
      step();
      push = 1'b0; pop = 1'b1;
      step();
      pop = 1'b0;
      n_cmp++; if (Fifo_Data_out !== 6'(i + 1) || Data_valid !== 1'b1 || Umbral !== 4'd0) begin n_err++; $display("FAIL wrap[%0d] got %h/%b/%0d exp %h/1/0", i, Fifo_Data_out, Data_valid, Umbral, 6'(i + 1)); end
    end
  endtask

  task automatic test_back_to_back;
    push = 1'b1; Fifo_Data_in = 6'h10;
    step();
    for (int j = 1; j <= 12; j++) begin
      push = 1'b1; pop = 1'b1; Fifo_Data_in = 6'(8'h10 + j);
      step();
      n_cmp++; if (Fifo_Data_out !== 6'(8'h10 + j - 1) || Data_valid !== 1'b1 || Umbral !== 4'd1) begin n_err++; $display("FAIL b2b[%0d] got %h/%b/%0d exp %h/1/1", j, Fifo_Data_out, Data_valid, Umbral, 6'(8'h10 + j - 1)); end
    end
    push = 1'b0; pop = 1'b1;
    step();
    pop = 1'b0;
    n_cmp++; if (Fifo_Data_out !== 6'h1C || Fifo_Empty !== 1'b1 || Error_Fifo !== 1'b0) begin n_err++; $display("FAIL b2b_last got %h/%b/%b exp 1c/1/0", Fifo_Data_out, Fifo_Empty, Error_Fifo); end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill();
    test_overflow();
    test_full_push_pop();
    test_drain();
    test_empty_push_pop();
    test_reset_mid();
    test_thresholds();
    test_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO that replaces the fixed 6-bit, 4-entry FIFO in the data path. Data width, depth, and almost-empty/almost-full thresholds are configurable. It handles simultaneous push and pop correctly, has a registered read port with a valid strobe, and exposes an occupancy count. The Pausa output provides back-pressure to the upstream producer. A sticky error flag reports overflow and underflow until software clears it.

Parameters:
DATA_WIDTH, 6, width of each data word.
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries.

Ports:
clk  input  1  single clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
push  input  1  write request, sampled on the clk edge.
pop  input  1  read request, sampled on the clk edge.
Fifo_Data_in  input  DATA_WIDTH  write data, captured when a push is accepted.
Umbral_bajo  input  ADDR_WIDTH+1  almost-empty threshold; quasi-static.
Umbral_alto  input  ADDR_WIDTH+1  almost-full threshold; quasi-static.
err_clear  input  1  clears Error_Fifo.
Fifo_Data_out  output  DATA_WIDTH  registered read data.
Data_valid  output  1  one-cycle strobe; Fifo_Data_out holds a newly popped word.
Umbral  output  ADDR_WIDTH+1  occupancy count, range 0..DEPTH.
Fifo_Empty  output  1  count == 0.
Fifo_Full  output  1  count == DEPTH.
Almost_Empty  output  1  count <= Umbral_bajo.
Almost_Full  output  1  count >= Umbral_alto.
Pausa  output  1  Almost_Full | Fifo_Full.
Error_Fifo  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset (synchronous, active-high), applied on any clk edge including mid-operation:
  - wr_ptr, rd_ptr and count go to 0.
  - Fifo_Data_out = 0, Data_valid = 0, Error_Fifo = 0.
  - Fifo_Empty = 1, Fifo_Full = 0, Almost_Empty = 1, Almost_Full = 0 (given Umbral_alto > 0), Pausa = 0.
  - Storage array is not cleared; stale contents are unreachable after reset.
- Acceptance rules, evaluated from the registered state at the edge:
  - pop_ok = pop & !Fifo_Empty.
  - push_ok = push & (!Fifo_Full | pop_ok). A push while full is accepted only when a pop is accepted in the same cycle.
- Pointer and count update per edge:
  - push_ok only: write mem[wr_ptr], wr_ptr+1, count+1.
  - pop_ok only: read mem[rd_ptr], rd_ptr+1, count-1.
  - Both: write and read in the same cycle; both pointers +1; count unchanged.
  - Pointers wrap modulo DEPTH naturally; count never leaves 0..DEPTH.
- Read latency: a pop accepted at edge N puts data on Fifo_Data_out after edge N, with Data_valid = 1 for exactly that one cycle. Fifo_Data_out holds its last value otherwise.
- Push and pop on an empty FIFO: push is accepted; pop is rejected (no fall-through); underflow error is set.
- Flags are decoded from the registered count and the threshold inputs only. There is no combinational path from push/pop to any flag.
- Threshold edge cases:
  - Umbral_alto = 0 forces Almost_Full = 1.
  - Umbral_bajo >= DEPTH forces Almost_Empty = 1.
  - Both are legal configurations.
- Error_Fifo is set on the edge where either occurs:
  - overflow: push while Fifo_Full and not pop_ok;
  - underflow: pop while Fifo_Empty.
- Error_Fifo stays high until err_clear. If err_clear and a new error occur on the same edge, the set wins.
- Rejected requests change no pointer, count or data.

Test Plan:
- Reset, then 8 pushes of 0x01..0x08 (DEPTH = 8, Umbral_alto = 6) -> Umbral counts 1..8; Almost_Full and Pausa rise after the 6th push; Fifo_Full = 1 after the 8th; Error_Fifo = 0.
- Full FIFO, push 0x3F with no pop -> rejected; Umbral stays 8; Error_Fifo = 1. Then err_clear -> Error_Fifo = 0.
- Full FIFO, push 0x2A and pop together -> Fifo_Data_out = 0x01 with Data_valid for one cycle; Umbral stays 8; no error; 0x2A is read out last.
- Drain with 8 pops (Umbral_bajo = 2) -> outputs appear in order one cycle after each pop; Almost_Empty rises at count 2; Fifo_Empty at count 0. A 9th pop -> Error_Fifo = 1, Data_valid = 0.
- Empty FIFO, push 0x15 and pop together -> Umbral = 1; Data_valid = 0; Error_Fifo = 1. The next pop returns 0x15.
- Push 5 words, assert reset for one cycle, then pop -> Fifo_Empty = 1, Umbral = 0, Data_valid = 0, Error_Fifo = 1 (underflow after reset). Wrap-around check: 20 alternating push/pop cycles return data in order.
